icetap_seq_capture: RTL and testbench

- Clock-domain capture core for the next-generation icetap logic analyser.
- Records NR_SIGNALS probe bits into a RECORD_DEPTH-deep circular buffer.
- Supports a programmable pre-trigger depth, a qualified store condition, an edge/level per-signal mask and a multi-stage trigger sequencer with occurrence counts.
- Sits behind the JTAG register bank. The parent synchronises all config and command inputs into clk before they reach this block. The parent reads status and buffer contents through a logical-address read port.

---
 rtl/icetap_pkg.sv | 35 +++
 rtl/icetap_cond_match.sv | 19 +
 rtl/icetap_seq_capture.sv | 185 ++++++++++++++++++
 tb/tb_icetap_seq_capture.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/icetap_pkg.sv
// Shared definitions for the icetap capture core: state encoding, probe mask
// codes and the per-signal condition evaluator.
package icetap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRE_FILL = 2'd1,
    ST_ARMED    = 2'd2,
    ST_POST     = 2'd3
  } state_t;

  localparam logic [2:0] MASK_DC   = 3'b000;
  localparam logic [2:0] MASK_HIGH = 3'b001;
  localparam logic [2:0] MASK_LOW  = 3'b010;
  localparam logic [2:0] MASK_RISE = 3'b011;
  localparam logic [2:0] MASK_FALL = 3'b100;
  localparam logic [2:0] MASK_EDGE = 3'b101;

  // Codes 11x fall through to don't-care along with MASK_DC.
  function automatic logic mask_bit_match(input logic [2:0] code,
                                          input logic       sample,
                                          input logic       prev);
    logic m;
    case (code)
      MASK_HIGH: m = sample;
      MASK_LOW:  m = ~sample;
      MASK_RISE: m = sample & ~prev;
      MASK_FALL: m = ~sample & prev;
      MASK_EDGE: m = sample ^ prev;
      default:   m = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/icetap_cond_match.sv
// AND of per-signal mask conditions; an all-zero mask always matches.
module icetap_cond_match
  import icetap_pkg::*;
#(
  parameter int NR_SIGNALS = 16
) (
  input  logic [3*NR_SIGNALS-1:0] mask,
  input  logic [NR_SIGNALS-1:0]   sample,
  input  logic [NR_SIGNALS-1:0]   prev,
  output logic                    match
);

  always_comb begin
    match = 1'b1;
    for (int unsigned i = 0; i < NR_SIGNALS; i++)
      match &= mask_bit_match(mask[3*i +: 3], sample[i], prev[i]);
  end

endmodule

// File: rtl/icetap_seq_capture.sv
// icetap capture core: circular sample buffer with pre-trigger fill, store
// qualifier and a multi-stage trigger sequencer; logical-index read port.
module icetap_seq_capture
  import icetap_pkg::*;
#(
  parameter int NR_SIGNALS   = 16,
  parameter int RECORD_DEPTH = 512,
  parameter int NR_STAGES    = 4,
  parameter int CNT_W        = 16,
  localparam int AW          = $clog2(RECORD_DEPTH),
  localparam int NSW         = $clog2(NR_STAGES) + 1
) (
  input  logic                              clk,
  input  logic                              reset_,
  input  logic [NR_SIGNALS-1:0]             signals_in,
  input  logic                              cmd_start,
  input  logic                              cmd_abort,
  input  logic [3*NR_SIGNALS-1:0]           store_mask,
  input  logic [NR_STAGES*3*NR_SIGNALS-1:0] trig_mask,
  input  logic [NR_STAGES*CNT_W-1:0]        trig_count,
  input  logic [NSW-1:0]                    nr_stages_used,
  input  logic [AW:0]                       pre_trigger_depth,
  output logic                              status_idle,
  output logic [1:0]                        status_state,
  output logic                              trigger_valid,
  output logic [AW-1:0]                     start_addr,
  output logic [AW-1:0]                     trigger_addr,
  output logic [AW-1:0]                     stop_addr,
  input  logic [AW-1:0]                     rd_addr,
  output logic [NR_SIGNALS-1:0]             rd_data
);

  localparam int SW = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1;

  state_t                  state, state_next;
  logic [AW-1:0]           wr_ptr;
  logic                    wrapped, wrapped_next;
  logic [AW:0]             fill_cnt, post_cnt, pre_eff, post_target;
  logic [SW-1:0]           stage;
  logic [CNT_W-1:0]        stage_cnt, tc_eff;
  logic [NSW-1:0]          used;
  logic                    first, at_last, cnt_done;
  logic                    store_hit, trig_fire, we, finish;
  logic [NR_STAGES-1:0]    stage_hit;
  logic [NR_SIGNALS-1:0]   prev, cmp_prev;
  logic [AW-1:0]           stop_next;
  logic [NR_SIGNALS-1:0]   mem [RECORD_DEPTH];

  // Using the sample itself as prev makes every edge code false on the first sample.
  assign cmp_prev     = first ? signals_in : prev;
  assign status_state = state;

  icetap_cond_match #(.NR_SIGNALS(NR_SIGNALS)) u_store (
    .mask(store_mask), .sample(signals_in), .prev(cmp_prev), .match(store_hit)
  );

  for (genvar g = 0; g < NR_STAGES; g++) begin : g_stage
    icetap_cond_match #(.NR_SIGNALS(NR_SIGNALS)) u_match (
      .mask  (trig_mask[g*3*NR_SIGNALS +: 3*NR_SIGNALS]),
      .sample(signals_in),
      .prev  (cmp_prev),
      .match (stage_hit[g])
    );
  end

  always_comb begin
    pre_eff     = (pre_trigger_depth > (AW+1)'(RECORD_DEPTH-1)) ?
                  (AW+1)'(RECORD_DEPTH-1) : pre_trigger_depth;
    post_target = (AW+1)'(RECORD_DEPTH) - pre_eff;

    used = nr_stages_used;
    if (used == '0) used = NSW'(1);
    if (used > NSW'(NR_STAGES)) used = NSW'(NR_STAGES);
    at_last = (NSW'(stage) == used - NSW'(1));

    tc_eff = trig_count[int'(stage)*CNT_W +: CNT_W];
    if (tc_eff == '0) tc_eff = CNT_W'(1);
    cnt_done = (stage_cnt + CNT_W'(1)) >= tc_eff;

    trig_fire  = (state == ST_ARMED) && !cmd_abort && stage_hit[stage] && cnt_done && at_last;
    state_next = state;
    we         = 1'b0;
    finish     = 1'b0;
    case (state)
      ST_IDLE:
        if (cmd_start && !cmd_abort) state_next = ST_PRE_FILL;
      ST_PRE_FILL:
        if (pre_eff == '0) state_next = ST_ARMED;
        else begin
          we = store_hit;
          if (fill_cnt + (AW+1)'(store_hit) == pre_eff) state_next = ST_ARMED;
        end
      ST_ARMED: begin
        we = store_hit | trig_fire;
        if (trig_fire) state_next = ST_POST;
      end
      ST_POST:
        if (post_cnt == post_target) finish = 1'b1;
        else begin
          we = store_hit;
          if (post_cnt + (AW+1)'(store_hit) == post_target) finish = 1'b1;
        end
      default: state_next = ST_IDLE;
    endcase
    if (state != ST_IDLE && cmd_abort) begin
      we     = 1'b0;
      finish = 1'b1;
    end
    if (finish) state_next = ST_IDLE;

    stop_next    = we ? wr_ptr : wr_ptr - AW'(1);
    wrapped_next = wrapped | (we && wr_ptr == '1);
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state         <= ST_IDLE;
      status_idle   <= 1'b1;
      trigger_valid <= 1'b0;
      start_addr    <= '0;
      trigger_addr  <= '0;
      stop_addr     <= '0;
      wr_ptr        <= '0;
      wrapped       <= 1'b0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      stage         <= '0;
      stage_cnt     <= '0;
      first         <= 1'b0;
      prev          <= '0;
    end else begin
      state       <= state_next;
      status_idle <= (state_next == ST_IDLE);
      if (state == ST_IDLE) begin
        if (state_next == ST_PRE_FILL) begin
          wr_ptr        <= '0;
          wrapped       <= 1'b0;
          fill_cnt      <= '0;
          post_cnt      <= '0;
          stage         <= '0;
          stage_cnt     <= '0;
          trigger_valid <= 1'b0;
          first         <= 1'b1;
        end
      end else begin
        prev  <= signals_in;
        first <= 1'b0;
        if (we) begin
          wr_ptr  <= wr_ptr + AW'(1);
          wrapped <= wrapped_next;
        end
        if (state == ST_PRE_FILL) fill_cnt <= fill_cnt + (AW+1)'(we);
        if (state == ST_ARMED && !cmd_abort) begin
          if (trig_fire) begin
            trigger_addr  <= wr_ptr;
            trigger_valid <= 1'b1;
            post_cnt      <= (AW+1)'(1);
          end else if (stage_hit[stage]) begin
            if (cnt_done) begin
              stage     <= stage + SW'(1);
              stage_cnt <= '0;
            end else begin
              stage_cnt <= stage_cnt + CNT_W'(1);
            end
          end
        end
        if (state == ST_POST && we) post_cnt <= post_cnt + (AW+1)'(1);
        if (finish) begin
          stop_addr  <= stop_next;
          start_addr <= wrapped_next ? stop_next + AW'(1) : '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= signals_in;
  end

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) rd_data <= '0;
    else        rd_data <= mem[start_addr + rd_addr];
  end

endmodule

// File: tb/tb_icetap_seq_capture.sv
// Self-checking bench for icetap_seq_capture: counting probe stimulus,
// scoreboarded buffer reads and direct status checks.
module tb_icetap_seq_capture;

  logic          clk = 1'b0;
  logic          reset_;
  logic [15:0]   signals_in;
  logic          cmd_start, cmd_abort;
  logic [47:0]   store_mask;
  logic [191:0]  trig_mask;
  logic [63:0]   trig_count;
  logic [2:0]    nr_stages_used;
  logic [9:0]    pre_trigger_depth;
  logic          status_idle, trigger_valid;
  logic [1:0]    status_state;
  logic [8:0]    start_addr, trigger_addr, stop_addr, rd_addr;
  logic [15:0]   rd_data;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [15:0]   cs;
  logic [8:0]    exp_a;
  int            req_idx[$];
  logic [15:0]   req_exp[$];
  int            sb_idx[$];
  logic [15:0]   sb_exp[$];

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) signals_in <= '0;
    else        signals_in <= signals_in + 16'd1;
  end

  icetap_seq_capture #(
    .NR_SIGNALS(16), .RECORD_DEPTH(512), .NR_STAGES(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_(reset_), .signals_in(signals_in),
    .cmd_start(cmd_start), .cmd_abort(cmd_abort),
    .store_mask(store_mask), .trig_mask(trig_mask), .trig_count(trig_count),
    .nr_stages_used(nr_stages_used), .pre_trigger_depth(pre_trigger_depth),
    .status_idle(status_idle), .status_state(status_state),
    .trigger_valid(trigger_valid), .start_addr(start_addr),
    .trigger_addr(trigger_addr), .stop_addr(stop_addr),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [47:0] level_mask(input logic [15:0] v);
    logic [47:0] m;
    for (int i = 0; i < 16; i++) m[3*i +: 3] = v[i] ? 3'b001 : 3'b010;
    return m;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_ = 1'b1;
    repeat (2) @(negedge clk);
    reset_ = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    cmd_start = 1'b1;
    cs = signals_in;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    for (int i = 0; i < max && !status_idle; i++) @(negedge clk);
    check(tag, status_idle, 1);
  endtask

  task automatic read_expect(input int idx, input logic [15:0] exp);
    req_idx.push_back(idx);
    req_exp.push_back(exp);
  endtask

  // One read issued per cycle; each result is checked the following cycle.
  task automatic run_reads();
    int n;
    n = req_idx.size();
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("rd[%0d]", sb_idx.pop_front()), rd_data, sb_exp.pop_front());
      if (i < n) begin
        rd_addr = 9'(req_idx[i]);
        sb_idx.push_back(req_idx[i]);
        sb_exp.push_back(req_exp[i]);
      end
    end
    req_idx.delete();
    req_exp.delete();
  endtask

  task automatic config_level(input logic [15:0] v, input logic [9:0] pre, input logic [15:0] cnt);
    store_mask        = '0;
    trig_mask         = '0;
    trig_mask[47:0]   = level_mask(v);
    trig_count        = '0;
    trig_count[15:0]  = cnt;
    nr_stages_used    = 3'd1;
    pre_trigger_depth = pre;
  endtask

  initial begin
    reset_ = 1'b1; cmd_start = 1'b0; cmd_abort = 1'b0; rd_addr = '0;
    config_level(16'h1c00, 10'd0, 16'd1);
    repeat (3) @(negedge clk);
    check("rst_idle", status_idle, 1);
    check("rst_state", status_state, 0);
    check("rst_tv", trigger_valid, 0);
    check("rst_start", start_addr, 0);
    check("rst_trig", trigger_addr, 0);
    check("rst_stop", stop_addr, 0);
    check("rst_rd", rd_data, 0);
    reset_ = 1'b0;

    // Level trigger, no pre-trigger history.
    pulse_start();
    check("t1_prefill", status_state, 1);
    wait_idle("t1_done", 10000);
    exp_a = 9'((16'h1c00 - cs - 16'd2) & 16'h1ff);
    check("t1_tv", trigger_valid, 1);
    check("t1_trig_addr", trigger_addr, exp_a);
    check("t1_start", start_addr, exp_a);
    check("t1_stop", stop_addr, 9'(exp_a - 9'd1));
    read_expect(0, 16'h1c00); read_expect(1, 16'h1c01); read_expect(511, 16'h1dff);
    run_reads();

    // 128 samples of pre-trigger history.
    do_reset();
    config_level(16'h1c00, 10'd128, 16'd1);
    pulse_start();
    wait_idle("t2_done", 10000);
    exp_a = 9'((16'h1c00 - cs - 16'd1) & 16'h1ff);
    check("t2_tv", trigger_valid, 1);
    check("t2_trig_addr", trigger_addr, exp_a);
    check("t2_stop", stop_addr, 9'(exp_a + 9'd383));
    check("t2_start", start_addr, 9'(exp_a + 9'd384));
    read_expect(0, 16'h1b80); read_expect(127, 16'h1bff);
    read_expect(128, 16'h1c00); read_expect(511, 16'h1d7f);
    run_reads();

    // Two stages: third rise of bit 12, then level 0x5010.
    do_reset();
    config_level(16'h5010, 10'd0, 16'd1);
    trig_mask[47:0]   = 48'(3'b011) << 36;
    trig_mask[95:48]  = level_mask(16'h5010);
    trig_count[15:0]  = 16'd3;
    trig_count[31:16] = 16'd1;
    nr_stages_used    = 3'd2;
    pulse_start();
    wait_idle("t3_done", 25000);
    check("t3_tv", trigger_valid, 1);
    read_expect(0, 16'h5010); read_expect(1, 16'h5011); read_expect(511, 16'h520f);
    run_reads();

    // Store only odd samples; the capture holds exactly 512 entries.
    do_reset();
    config_level(16'h1c01, 10'd0, 16'd1);
    store_mask = 48'h1;
    pulse_start();
    wait_idle("t4_done", 10000);
    check("t4_tv", trigger_valid, 1);
    check("t4_start_is_trig", start_addr, trigger_addr);
    read_expect(0, 16'h1c01); read_expect(1, 16'h1c03); read_expect(511, 16'h1fff);
    run_reads();

    // Simultaneous start/abort, abort while armed, reset during POST.
    do_reset();
    config_level(16'hffff, 10'd0, 16'd1);
    @(negedge clk);
    cmd_start = 1'b1; cmd_abort = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_abort = 1'b0;
    check("t5_abort_wins", status_idle, 1);
    pulse_start();
    repeat (4) @(negedge clk);
    check("t5_armed", status_state, 2);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    check("t5_abort_idle", status_idle, 1);
    check("t5_abort_tv", trigger_valid, 0);
    config_level(16'h0100, 10'd0, 16'd1);
    pulse_start();
    for (int i = 0; i < 1000 && status_state != 2'd3; i++) @(negedge clk);
    check("t5_post", status_state, 3);
    check("t5_post_tv", trigger_valid, 1);
    reset_ = 1'b1;
    #2;
    check("t5_rst_idle", status_idle, 1);
    check("t5_rst_state", status_state, 0);
    check("t5_rst_tv", trigger_valid, 0);
    check("t5_rst_trig", trigger_addr, 0);
    @(negedge clk);
    reset_ = 1'b0;

    // Oversized pre-trigger depth clamps to 511; count 0 fires on first match.
    do_reset();
    config_level(16'h1c00, 10'd600, 16'd0);
    pulse_start();
    wait_idle("t6_done", 10000);
    exp_a = 9'((16'h1c00 - cs - 16'd1) & 16'h1ff);
    check("t6_tv", trigger_valid, 1);
    check("t6_trig_addr", trigger_addr, exp_a);
    check("t6_stop", stop_addr, exp_a);
    check("t6_start", start_addr, 9'(exp_a + 9'd1));
    read_expect(511, 16'h1c00); read_expect(510, 16'h1bff); read_expect(0, 16'h1a01);
    run_reads();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
